// File: rtl/muldiv_pkg.sv
// Shared op codes, read-select codes and FSM state encoding for the HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MADDU = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [1:0] RD_HI = 2'b01;
    localparam logic [1:0] RD_LO = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    function automatic logic is_iterative(input logic [2:0] op);
        return (op == OP_MULTU) || (op == OP_MADDU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on the {upper,lower} pair.
// Purely combinational; the caller owns all state.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             div,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] upper,
    input  logic [WIDTH-1:0] lower,
    output logic [WIDTH-1:0] next_upper,
    output logic [WIDTH-1:0] next_lower
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] partial;
    logic [WIDTH:0] trial;
    logic           fits;

    always_comb begin
        // Multiply: lower holds the not-yet-consumed multiplier bits, product shifts in from the top.
        sum     = {1'b0, upper} + (lower[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        // Divide: upper is the running remainder, lower shifts dividend out and quotient in.
        partial = {upper, lower[WIDTH-1]};
        trial   = partial - {1'b0, operand};
        fits    = (partial >= {1'b0, operand});

        next_upper = sum[WIDTH:1];
        next_lower = {sum[0], lower[WIDTH-1:1]};
        if (div) begin
            if (fits) begin
                next_upper = trial[WIDTH-1:0];
                next_lower = {lower[WIDTH-2:0], 1'b1};
            end else begin
                next_upper = partial[WIDTH-1:0];
                next_lower = {lower[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative HI/LO multiply/divide unit: WIDTH RUN cycles plus one COMMIT, done pulses the cycle HI/LO update.
// start is ignored while busy; readers of HI/LO are stalled during RUN, the result is forwarded in COMMIT.
module hilo_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic [1:0]       rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t             state;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic               is_div;
    logic [WIDTH-1:0]   step_operand;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] mac_sum;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic [WIDTH-1:0]   view_hi;
    logic [WIDTH-1:0]   view_lo;

    assign is_div       = (op_q == OP_DIVU);
    assign step_operand = is_div ? b_q : a_q;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div        (is_div),
        .operand    (step_operand),
        .upper      (acc_hi),
        .lower      (acc_lo),
        .next_upper (step_hi),
        .next_lower (step_lo)
    );

    // HI/LO cannot change while busy, so the committed pair still equals the start-edge addend.
    assign mac_sum = {acc_hi, acc_lo} + {hi_q, lo_q};

    always_comb begin
        res_hi = acc_hi;
        res_lo = acc_lo;
        if (op_q == OP_MADDU) begin
            res_hi = mac_sum[2*WIDTH-1:WIDTH];
            res_lo = mac_sum[WIDTH-1:0];
        end
    end

    always_comb begin
        view_hi = (state == ST_COMMIT) ? res_hi : hi_q;
        view_lo = (state == ST_COMMIT) ? res_lo : lo_q;
        case (rd_sel)
            RD_HI:   rd_data = view_hi;
            RD_LO:   rd_data = view_lo;
            default: rd_data = '0;
        endcase
    end

    assign busy  = (state != ST_IDLE);
    assign stall = (state == ST_RUN) && ((rd_sel == RD_HI) || (rd_sel == RD_LO));
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            op_q   <= OP_NOP;
            a_q    <= '0;
            b_q    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (is_iterative(op)) begin
                                op_q   <= op;
                                a_q    <= src_a;
                                b_q    <= src_b;
                                cnt    <= '0;
                                acc_hi <= '0;
                                acc_lo <= (op == OP_DIVU) ? src_a : src_b;
                                state  <= ST_RUN;
                            end else if (op == OP_MTHI) begin
                                hi_q <= src_a;
                            end else if (op == OP_MTLO) begin
                                lo_q <= src_a;
                            end
                        end
                    end
                    ST_RUN: begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        cnt    <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= ST_COMMIT;
                        end
                    end
                    ST_COMMIT: begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
